// File: rtl/inst_sram_axi_bridge.sv
// inst_sram_axi_bridge
// Turns IF-stage inst_sram fetches into single-beat AXI4 reads, one outstanding
// read at a time, and stalls the pipeline until the word is available.
// Optional feature: define INST_BRIDGE_ACCERR_EN to report a non-OKAY rresp on
// fetch_err_o; otherwise rresp is ignored and fetch_err_o is tied low.
module inst_sram_axi_bridge #(
   parameter int              ID_W     = 4,
   parameter logic [ID_W-1:0] AXI_ID   = '0,
   parameter bit              KSEG_MAP = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inst_sram_en,
   input  logic [31:0]     inst_sram_addr,
   input  logic            flush_i,
   output logic [31:0]     inst_sram_rdata,
   output logic            stall_req_o,
   output logic            fetch_err_o,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DATA} state_t;

   state_t      state, state_nxt;
   logic [31:0] araddr_q;
   logic [31:0] rdata_q;
   logic        discard;
   logic        drop_beat;

   // kseg0/kseg1 fold onto the physical window; the low two bits never reach the bus
   function automatic logic [31:0] map_addr(input logic [31:0] a);
      logic [31:0] m;
      m = a;
      if (KSEG_MAP && (a[31:30] == 2'b10)) m = a & 32'h1FFF_FFFF;
      return {m[31:2], 2'b00};
   endfunction

   // A flush arriving with the beat itself counts the same as an earlier one
   assign drop_beat = discard | flush_i;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: AR is never withdrawn and R is always drained
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (inst_sram_en) state_nxt = S_AR;
         S_AR:   if (arready)      state_nxt = S_R;
         S_R:    if (rvalid)       state_nxt = drop_beat ? S_IDLE : S_DATA;
         S_DATA: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: handshakes and pipeline stall
   always_comb begin
      arvalid     = 1'b0;
      rready      = 1'b0;
      stall_req_o = 1'b0;
      case (state)
         S_IDLE: stall_req_o = inst_sram_en;
         S_AR: begin
            arvalid     = 1'b1;
            stall_req_o = 1'b1;
         end
         S_R: begin
            rready      = 1'b1;
            stall_req_o = 1'b1;
         end
         default: stall_req_o = 1'b0;
      endcase
      if (!rst_n) stall_req_o = 1'b0;
   end

   // Address latch, flush bookkeeping and read-data capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         araddr_q <= '0;
         rdata_q  <= '0;
         discard  <= 1'b0;
      end else begin
         if ((state == S_IDLE) && inst_sram_en) araddr_q <= map_addr(inst_sram_addr);
         if (((state == S_AR) || (state == S_R)) && flush_i) discard <= 1'b1;
         if ((state == S_R) && rvalid) begin
            if (drop_beat) discard <= 1'b0;
            else           rdata_q <= rdata;
         end
      end
   end

`ifdef INST_BRIDGE_ACCERR_EN
   logic err_q;

   // Error flag travels with the captured word; dropped beats leave it alone
   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else if ((state == S_R) && rvalid && !drop_beat) err_q <= (rresp != 2'b00);
   end

   assign fetch_err_o = err_q;

   logic unused_ok;
   assign unused_ok = ^{rid, rlast};
`else
   assign fetch_err_o = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{rid, rlast, rresp};
`endif

   assign inst_sram_rdata = rdata_q;
   assign araddr          = araddr_q;
   assign arid            = AXI_ID;
   assign arlen           = 8'd0;
   assign arsize          = 3'b010;
   assign arburst         = 2'b01;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge: a KSEG-mapping instance and a
// pass-through instance share all inputs and are checked per cycle.
module tb_inst_sram_axi_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [31:0] addr;
   logic        flush;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata_in;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;

   logic [31:0] inst_rdata, pt_inst_rdata;
   logic        stall, pt_stall;
   logic        fetch_err, pt_fetch_err;
   logic [3:0]  arid, pt_arid;
   logic [31:0] araddr, pt_araddr;
   logic [7:0]  arlen, pt_arlen;
   logic [2:0]  arsize, pt_arsize;
   logic [1:0]  arburst, pt_arburst;
   logic        arvalid, pt_arvalid;
   logic        rready, pt_rready;

   int n_checks = 0;
   int n_pass   = 0;
   int ar_hs    = 0;

`ifdef INST_BRIDGE_ACCERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   inst_sram_axi_bridge #(.ID_W(4), .AXI_ID(4'd0), .KSEG_MAP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .inst_sram_en(en), .inst_sram_addr(addr), .flush_i(flush),
      .inst_sram_rdata(inst_rdata), .stall_req_o(stall), .fetch_err_o(fetch_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata_in), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   inst_sram_axi_bridge #(.ID_W(4), .AXI_ID(4'd0), .KSEG_MAP(1'b0)) dut_pt (
      .clk(clk), .rst_n(rst_n), .inst_sram_en(en), .inst_sram_addr(addr), .flush_i(flush),
      .inst_sram_rdata(pt_inst_rdata), .stall_req_o(pt_stall), .fetch_err_o(pt_fetch_err),
      .arid(pt_arid), .araddr(pt_araddr), .arlen(pt_arlen), .arsize(pt_arsize), .arburst(pt_arburst),
      .arvalid(pt_arvalid), .arready(arready), .rid(rid), .rdata(rdata_in), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(pt_rready)
   );

   // Count AR handshakes on the mapped instance
   always @(posedge clk) if (rst_n && arvalid && arready) ar_hs = ar_hs + 1;

   // Stimulus only: one fetch with immediate handshakes, returns in the DATA cycle
   task automatic run_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      @(negedge clk); en = 1'b1; addr = a; arready = 1'b1; rvalid = 1'b0;
      @(negedge clk);
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata_in = d; rresp = r;
      @(negedge clk); rvalid = 1'b0; rresp = 2'b00; en = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; addr = 32'hBFC0_0000; flush = 1'b0; arready = 1'b0;
      rvalid = 1'b0; rdata_in = '0; rresp = 2'b00; rid = '0; rlast = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall_forced: got %b want 0", stall); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if ({arvalid, rready} !== 2'b00) $display("FAIL reset_handshakes: got %b want 00", {arvalid, rready}); else n_pass++;
      n_checks++; if (inst_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", inst_rdata); else n_pass++;
      n_checks++; if (fetch_err !== 1'b0) $display("FAIL reset_err: got %b want 0", fetch_err); else n_pass++;
      en = 1'b0; rst_n = 1'b1; #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL reset_idle_stall: got %b want 0", stall); else n_pass++;
   endtask

   task automatic test_basic_fetch();
      @(negedge clk); en = 1'b1; addr = 32'hBFC0_0000; arready = 1'b1; #1;
      n_checks++; if ({stall, arvalid} !== 2'b10) $display("FAIL basic_idle: got %b want 10", {stall, arvalid}); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if ({stall, arvalid} !== 2'b11) $display("FAIL basic_ar: got %b want 11", {stall, arvalid}); else n_pass++;
      n_checks++; if (araddr !== 32'h1FC0_0000) $display("FAIL basic_araddr: got %h want 1fc00000", araddr); else n_pass++;
      n_checks++; if (pt_araddr !== 32'hBFC0_0000) $display("FAIL basic_pt_araddr: got %h want bfc00000", pt_araddr); else n_pass++;
      n_checks++; if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd0, 3'b010, 2'b01})
         $display("FAIL basic_ar_fields: got %h want %h", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b010, 2'b01}); else n_pass++;
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata_in = 32'h1234_5678; #1;
      n_checks++; if ({stall, rready, arvalid} !== 3'b110) $display("FAIL basic_r: got %b want 110", {stall, rready, arvalid}); else n_pass++;
      @(negedge clk); rvalid = 1'b0; en = 1'b0; #1;
      n_checks++; if ({stall, rready} !== 2'b00) $display("FAIL basic_data_ctl: got %b want 00", {stall, rready}); else n_pass++;
      n_checks++; if (inst_rdata !== 32'h1234_5678) $display("FAIL basic_data_word: got %h want 12345678", inst_rdata); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (inst_rdata !== 32'h1234_5678) $display("FAIL basic_word_held: got %h want 12345678", inst_rdata); else n_pass++;
      n_checks++; if ({stall, arvalid} !== 2'b00) $display("FAIL basic_idle_after: got %b want 00", {stall, arvalid}); else n_pass++;
   endtask

   task automatic test_delayed_handshake();
      int hs0;
      hs0 = ar_hs;
      @(negedge clk); en = 1'b1; addr = 32'h0040_0013; arready = 1'b0; #1;
      n_checks++; if (stall !== 1'b1) $display("FAIL delay_idle_stall: got %b want 1", stall); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_checks++; if ({arvalid, stall, araddr} !== {2'b11, 32'h0040_0010})
            $display("FAIL delay_ar_wait%0d: got %b %b %h want 1 1 00400010", i, arvalid, stall, araddr); else n_pass++;
      end
      @(negedge clk); arready = 1'b1; #1;
      n_checks++; if (arvalid !== 1'b1) $display("FAIL delay_ar_accept: got %b want 1", arvalid); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); arready = 1'b0; #1;
         n_checks++; if ({rready, arvalid, stall} !== 3'b101)
            $display("FAIL delay_r_wait%0d: got %b want 101", i, {rready, arvalid, stall}); else n_pass++;
      end
      @(negedge clk); rvalid = 1'b1; rdata_in = 32'hA5A5_0001;
      @(negedge clk); rvalid = 1'b0; en = 1'b0; #1;
      n_checks++; if ({stall, inst_rdata} !== {1'b0, 32'hA5A5_0001})
         $display("FAIL delay_data: got %b %h want 0 a5a50001", stall, inst_rdata); else n_pass++;
      n_checks++; if (ar_hs - hs0 !== 1) $display("FAIL delay_one_ar: got %0d want 1", ar_hs - hs0); else n_pass++;
   endtask

   task automatic test_flush_in_r();
      @(negedge clk); en = 1'b1; addr = 32'h0000_2000; arready = 1'b1;
      @(negedge clk);
      @(negedge clk); arready = 1'b0; flush = 1'b1; #1;
      n_checks++; if ({stall, rready} !== 2'b11) $display("FAIL flushr_r: got %b want 11", {stall, rready}); else n_pass++;
      @(negedge clk); flush = 1'b0; rvalid = 1'b1; rdata_in = 32'hDEAD_BEEF; #1;
      n_checks++; if ({stall, rready} !== 2'b11) $display("FAIL flushr_drain: got %b want 11", {stall, rready}); else n_pass++;
      @(negedge clk); rvalid = 1'b0; addr = 32'h0000_3000; #1;
      n_checks++; if ({arvalid, rready, stall} !== 3'b001) $display("FAIL flushr_no_data: got %b want 001", {arvalid, rready, stall}); else n_pass++;
      n_checks++; if (inst_rdata !== 32'hA5A5_0001) $display("FAIL flushr_word_kept: got %h want a5a50001", inst_rdata); else n_pass++;
      @(negedge clk); arready = 1'b1; #1;
      n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h0000_3000}) $display("FAIL flushr_new_ar: got %b %h want 1 00003000", arvalid, araddr); else n_pass++;
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata_in = 32'hCAFE_0003;
      @(negedge clk); rvalid = 1'b0; en = 1'b0; #1;
      n_checks++; if ({stall, inst_rdata} !== {1'b0, 32'hCAFE_0003}) $display("FAIL flushr_new_data: got %b %h want 0 cafe0003", stall, inst_rdata); else n_pass++;
   endtask

   task automatic test_flush_in_ar();
      @(negedge clk); en = 1'b1; addr = 32'h0000_7000; arready = 1'b0;
      @(negedge clk); flush = 1'b1; #1;
      n_checks++; if (arvalid !== 1'b1) $display("FAIL flushar_ar: got %b want 1", arvalid); else n_pass++;
      @(negedge clk); flush = 1'b0; arready = 1'b1; #1;
      n_checks++; if ({arvalid, stall} !== 2'b11) $display("FAIL flushar_not_withdrawn: got %b want 11", {arvalid, stall}); else n_pass++;
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata_in = 32'h7777_7777;
      @(negedge clk); rvalid = 1'b0; en = 1'b0; #1;
      n_checks++; if ({stall, arvalid, rready, inst_rdata} !== {3'b000, 32'hCAFE_0003})
         $display("FAIL flushar_dropped: got %b %h want 000 cafe0003", {stall, arvalid, rready}, inst_rdata); else n_pass++;
   endtask

   task automatic test_flush_with_rvalid();
      @(negedge clk); en = 1'b1; addr = 32'h0000_4000; arready = 1'b1;
      @(negedge clk);
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; flush = 1'b1; rdata_in = 32'h1111_2222; rresp = 2'b10;
      @(negedge clk); rvalid = 1'b0; flush = 1'b0; rresp = 2'b00; en = 1'b0; #1;
      n_checks++; if ({stall, arvalid, rready} !== 3'b000) $display("FAIL flushrv_idle: got %b want 000", {stall, arvalid, rready}); else n_pass++;
      n_checks++; if (inst_rdata !== 32'hCAFE_0003) $display("FAIL flushrv_word_kept: got %h want cafe0003", inst_rdata); else n_pass++;
      n_checks++; if (fetch_err !== 1'b0) $display("FAIL flushrv_err_untouched: got %b want 0", fetch_err); else n_pass++;
      en = 1'b1; #1;
      n_checks++; if (stall !== 1'b1) $display("FAIL flushrv_stall_follows_en: got %b want 1", stall); else n_pass++;
      en = 1'b0; #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL flushrv_stall_drops: got %b want 0", stall); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (arvalid !== 1'b0) $display("FAIL flushrv_no_ar: got %b want 0", arvalid); else n_pass++;
   endtask

   task automatic test_passthrough();
      @(negedge clk); en = 1'b1; addr = 32'h8000_1003; arready = 1'b1;
      @(negedge clk); #1;
      n_checks++; if ({pt_arvalid, pt_araddr} !== {1'b1, 32'h8000_1000}) $display("FAIL pt_araddr: got %b %h want 1 80001000", pt_arvalid, pt_araddr); else n_pass++;
      n_checks++; if (araddr !== 32'h0000_1000) $display("FAIL kseg_araddr: got %h want 00001000", araddr); else n_pass++;
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata_in = 32'h5555_AAAA;
      @(negedge clk); rvalid = 1'b0; en = 1'b0; #1;
      n_checks++; if ({pt_stall, pt_inst_rdata} !== {1'b0, 32'h5555_AAAA}) $display("FAIL pt_data: got %b %h want 0 5555aaaa", pt_stall, pt_inst_rdata); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++; if ({pt_arvalid, pt_stall, arvalid, stall} !== 4'b0000)
            $display("FAIL pt_en0_idle%0d: got %b want 0000", i, {pt_arvalid, pt_stall, arvalid, stall}); else n_pass++;
      end
   endtask

   task automatic test_accerr();
      run_fetch(32'h0000_6000, 32'h6666_0000, 2'b10);
      n_checks++; if (fetch_err !== EXP_ERR) $display("FAIL err_slverr: got %b want %b", fetch_err, EXP_ERR); else n_pass++;
      n_checks++; if (inst_rdata !== 32'h6666_0000) $display("FAIL err_word: got %h want 66660000", inst_rdata); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (fetch_err !== EXP_ERR) $display("FAIL err_held: got %b want %b", fetch_err, EXP_ERR); else n_pass++;
      run_fetch(32'h0000_6004, 32'h6666_0001, 2'b00);
      n_checks++; if ({fetch_err, inst_rdata} !== {1'b0, 32'h6666_0001}) $display("FAIL err_cleared: got %b %h want 0 66660001", fetch_err, inst_rdata); else n_pass++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk); en = 1'b1; addr = 32'h0000_9000; arready = 1'b1;
      @(negedge clk);
      @(negedge clk); arready = 1'b0; rst_n = 1'b0; #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL rstmid_stall_forced: got %b want 0", stall); else n_pass++;
      @(negedge clk); rst_n = 1'b1; en = 1'b0; #1;
      n_checks++; if ({arvalid, rready, stall, fetch_err, inst_rdata} !== 36'h0)
         $display("FAIL rstmid_idle: got %b %h want 0000 0", {arvalid, rready, stall, fetch_err}, inst_rdata); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  exp_stall;
      logic [31:0] exp_addr;
      exp_stall = 8'b0111_0111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         en = 1'b1; arready = 1'b1;
         addr = (i < 4) ? 32'h0000_A000 : 32'h0000_B000;
         rvalid = ((i % 4) == 2);
         rdata_in = (i < 4) ? 32'hB2B0_0001 : 32'hB2B0_0002;
         exp_addr = addr;
         #1;
         n_checks++; if (stall !== exp_stall[i]) $display("FAIL b2b_stall%0d: got %b want %b", i, stall, exp_stall[i]); else n_pass++;
         if ((i % 4) == 1) begin
            n_checks++; if ({arvalid, araddr} !== {1'b1, exp_addr}) $display("FAIL b2b_ar%0d: got %b %h want 1 %h", i, arvalid, araddr, exp_addr); else n_pass++;
         end
         if ((i % 4) == 3) begin
            n_checks++; if (inst_rdata !== rdata_in) $display("FAIL b2b_word%0d: got %h want %h", i, inst_rdata, rdata_in); else n_pass++;
         end
      end
      @(negedge clk); en = 1'b0; rvalid = 1'b0; arready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_delayed_handshake();
      test_flush_in_r();
      test_flush_in_ar();
      test_flush_with_rvalid();
      test_passthrough();
      test_accerr();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
